// File: rtl/pc_sequencer_if.sv
// Handshake bundle between the hazard/branch logic and the PC sequencer.
// Signal names keep the fetch-unit port names so waveforms line up with the datapath.
interface pc_sequencer_if;
    logic        start_i;
    logic        stall_i;
    logic        branch_i;
    logic [31:0] branch_target_i;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        sel_taken_o;
    logic        pc_we_o;
    logic        ifid_we_o;
    logic        flush_o;
    logic        fault_o;
    logic        stall_timeout_o;
    logic [15:0] stall_cnt_o;
    logic [15:0] redirect_cnt_o;

    modport master (
        output start_i, stall_i, branch_i, branch_target_i,
        input  pc_o, pc_plus4_o, sel_taken_o, pc_we_o, ifid_we_o, flush_o,
        input  fault_o, stall_timeout_o, stall_cnt_o, redirect_cnt_o
    );

    modport slave (
        input  start_i, stall_i, branch_i, branch_target_i,
        output pc_o, pc_plus4_o, sel_taken_o, pc_we_o, ifid_we_o, flush_o,
        output fault_o, stall_timeout_o, stall_cnt_o, redirect_cnt_o
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter owner for the pipelined CPU: selects PC+4 vs. branch target,
// gates PC and IF/ID writes on stalls, traps misaligned targets into HALT and
// keeps saturating stall/redirect counters plus a stall-run watchdog.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          STALL_LIMIT = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    pc_sequencer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    // Watchdog threshold; the run-length counter never needs to exceed it.
    localparam logic [15:0] LIMIT = 16'(STALL_LIMIT);

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [15:0] run_len;
    logic [15:0] stall_cnt;
    logic [15:0] redirect_cnt;
    logic        fault;
    logic        stall_timeout;
    logic        aligned;
    logic        sel_taken;
    logic        pc_we;
    logic        ifid_we;
    logic        flush;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign pc_plus4 = pc + 32'd4;
    assign aligned  = (bus.branch_target_i[1:0] == 2'b00);

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state: start leaves IDLE, a misaligned taken branch traps into HALT.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start_i) state_next = RUN;
            RUN:     if (!bus.stall_i && bus.branch_i && !aligned) state_next = HALT;
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    // Mux select and write enables; stall beats branch beats sequential fetch.
    always_comb begin
        sel_taken = 1'b0;
        pc_we     = 1'b0;
        ifid_we   = 1'b0;
        flush     = 1'b0;
        if (state == RUN && !bus.stall_i) begin
            if (bus.branch_i) begin
                // A misaligned target still squashes the fetched instruction but
                // leaves the PC pointing at the fetch after the branch.
                flush = 1'b1;
                if (aligned) begin
                    sel_taken = 1'b1;
                    pc_we     = 1'b1;
                    ifid_we   = 1'b1;
                end
            end else begin
                pc_we   = 1'b1;
                ifid_we = 1'b1;
            end
        end
    end

    // PC register, redirect counter and sticky fault flag.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            pc           <= RESET_PC;
            redirect_cnt <= '0;
            fault        <= 1'b0;
        end else begin
            if (pc_we) pc <= sel_taken ? bus.branch_target_i : pc_plus4;
            if (sel_taken) redirect_cnt <= sat_inc(redirect_cnt);
            if (state == RUN && !bus.stall_i && bus.branch_i && !aligned) fault <= 1'b1;
        end
    end

    // Stall accounting: total stall count plus the run-length watchdog.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            run_len       <= '0;
            stall_cnt     <= '0;
            stall_timeout <= 1'b0;
        end else if (state == RUN) begin
            if (bus.stall_i) begin
                stall_cnt <= sat_inc(stall_cnt);
                if (run_len != LIMIT) run_len <= run_len + 16'd1;
                // This edge completes the LIMIT-th consecutive stall cycle.
                if (run_len >= LIMIT - 16'd1) stall_timeout <= 1'b1;
            end else begin
                run_len <= '0;
            end
        end
    end

    assign bus.pc_o            = pc;
    assign bus.pc_plus4_o      = pc_plus4;
    assign bus.sel_taken_o     = sel_taken;
    assign bus.pc_we_o         = pc_we;
    assign bus.ifid_we_o       = ifid_we;
    assign bus.flush_o         = flush;
    assign bus.fault_o         = fault;
    assign bus.stall_timeout_o = stall_timeout;
    assign bus.stall_cnt_o     = stall_cnt;
    assign bus.redirect_cnt_o  = redirect_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the PC sequencing rules.
module tb_pc_sequencer;

    localparam int LIM_A = 4;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst = 1'b0, a_start = 1'b0, a_stall = 1'b0, a_branch = 1'b0;
    logic [31:0] a_target = '0;
    logic        b_rst = 1'b0, b_start = 1'b0, b_stall = 1'b0, b_branch = 1'b0;
    logic [31:0] b_target = '0;

    int checks = 0;
    int passes = 0;

    pc_sequencer_if bus_a();
    pc_sequencer_if bus_b();

    assign bus_a.start_i = a_start;
    assign bus_a.stall_i = a_stall;
    assign bus_a.branch_i = a_branch;
    assign bus_a.branch_target_i = a_target;
    assign bus_b.start_i = b_start;
    assign bus_b.stall_i = b_stall;
    assign bus_b.branch_i = b_branch;
    assign bus_b.branch_target_i = b_target;

    pc_sequencer #(.RESET_PC(32'h0000_0000), .STALL_LIMIT(LIM_A)) dut_a (
        .clk_i(clk), .rst_i(a_rst), .bus(bus_a)
    );
    pc_sequencer #(.RESET_PC(32'hFFFF_FFF8), .STALL_LIMIT(16)) dut_b (
        .clk_i(clk), .rst_i(b_rst), .bus(bus_b)
    );

    // Behavioural model of dut_a.
    int          m_mode = M_IDLE;
    logic [31:0] m_pc = '0;
    int          m_scnt = 0, m_rcnt = 0, m_run = 0;
    logic        m_fault = 1'b0, m_to = 1'b0;

    function automatic logic [101:0] model_outs();
        logic sel, we, ifid, fl;
        logic act;
        act  = (m_mode == M_RUN) && !a_stall;
        fl   = act && a_branch;
        sel  = fl && (a_target % 4 == 0);
        we   = act && (!a_branch || sel);
        ifid = we;
        return {m_pc, m_pc + 32'd4, sel, we, ifid, fl, m_fault, m_to, 16'(m_scnt), 16'(m_rcnt)};
    endfunction

    function automatic logic [101:0] dut_outs();
        return {bus_a.pc_o, bus_a.pc_plus4_o, bus_a.sel_taken_o, bus_a.pc_we_o,
                bus_a.ifid_we_o, bus_a.flush_o, bus_a.fault_o, bus_a.stall_timeout_o,
                bus_a.stall_cnt_o, bus_a.redirect_cnt_o};
    endfunction

    task automatic model_update();
        if (!a_rst) begin
            m_mode = M_IDLE; m_pc = 32'h0; m_scnt = 0; m_rcnt = 0; m_run = 0;
            m_fault = 1'b0; m_to = 1'b0;
        end else if (m_mode == M_IDLE) begin
            if (a_start) m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (a_stall) begin
                if (m_scnt < 65535) m_scnt++;
                if (m_run < LIM_A) m_run++;
                if (m_run >= LIM_A) m_to = 1'b1;
            end else begin
                m_run = 0;
                if (a_branch && (a_target % 4 == 0)) begin
                    m_pc = a_target;
                    if (m_rcnt < 65535) m_rcnt++;
                end else if (a_branch) begin
                    m_fault = 1'b1;
                    m_mode  = M_HALT;
                end else begin
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic apply(input logic r, input logic s, input logic st, input logic b, input logic [31:0] t);
        a_rst = r; a_start = s; a_stall = st; a_branch = b; a_target = t;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic restart();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 32'h0); tick();
        apply(1'b1, 1'b1, 1'b0, 1'b0, 32'h0); tick();
        apply(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 32'h0); tick();
        apply(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (bus_a.pc_o !== 32'h0) $display("FAIL reset_pc got=%h exp=%h", bus_a.pc_o, 32'h0); else passes++;
        checks++; if (bus_a.pc_we_o !== 1'b0) $display("FAIL reset_pc_we got=%b exp=0", bus_a.pc_we_o); else passes++;
        checks++; if (bus_a.fault_o !== 1'b0 || bus_a.stall_timeout_o !== 1'b0) $display("FAIL reset_flags got=%b%b exp=00", bus_a.fault_o, bus_a.stall_timeout_o); else passes++;
        checks++; if (bus_a.stall_cnt_o !== 16'h0 || bus_a.redirect_cnt_o !== 16'h0) $display("FAIL reset_cnts got=%h/%h exp=0/0", bus_a.stall_cnt_o, bus_a.redirect_cnt_o); else passes++;
    endtask

    task automatic test_sequential();
        apply(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checks++; if (bus_a.pc_o !== 32'h0 || bus_a.pc_we_o !== 1'b0) $display("FAIL seq_idle got pc=%h we=%b exp pc=0 we=0", bus_a.pc_o, bus_a.pc_we_o); else passes++;
        tick();
        apply(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (bus_a.pc_o !== 32'h0 || bus_a.pc_we_o !== 1'b1) $display("FAIL seq_first got pc=%h we=%b exp pc=0 we=1", bus_a.pc_o, bus_a.pc_we_o); else passes++;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (bus_a.pc_o !== 32'(4 * i)) $display("FAIL seq_pc got=%h exp=%h", bus_a.pc_o, 32'(4 * i)); else passes++;
        end
    endtask

    task automatic test_branch();
        restart();
        for (int i = 0; i < 4; i++) tick();
        apply(1'b1, 1'b0, 1'b0, 1'b1, 32'h100);
        checks++; if (bus_a.pc_o !== 32'h10) $display("FAIL br_at got=%h exp=%h", bus_a.pc_o, 32'h10); else passes++;
        checks++; if (bus_a.sel_taken_o !== 1'b1 || bus_a.flush_o !== 1'b1) $display("FAIL br_ctl got sel=%b fl=%b exp 1 1", bus_a.sel_taken_o, bus_a.flush_o); else passes++;
        tick();
        apply(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (bus_a.pc_o !== 32'h100) $display("FAIL br_tgt got=%h exp=%h", bus_a.pc_o, 32'h100); else passes++;
        checks++; if (bus_a.redirect_cnt_o !== 16'd1) $display("FAIL br_rcnt got=%0d exp=1", bus_a.redirect_cnt_o); else passes++;
        tick();
        checks++; if (bus_a.pc_o !== 32'h104) $display("FAIL br_next got=%h exp=%h", bus_a.pc_o, 32'h104); else passes++;
    endtask

    task automatic test_stall_branch();
        restart();
        apply(1'b1, 1'b0, 1'b0, 1'b1, 32'h20); tick();
        apply(1'b1, 1'b0, 1'b1, 1'b1, 32'h200);
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus_a.pc_o !== 32'h20 || bus_a.ifid_we_o !== 1'b0 || bus_a.flush_o !== 1'b0) $display("FAIL stall_hold got pc=%h ifid=%b fl=%b exp 20 0 0", bus_a.pc_o, bus_a.ifid_we_o, bus_a.flush_o); else passes++;
            tick();
        end
        checks++; if (bus_a.stall_cnt_o !== 16'd3) $display("FAIL stall_cnt got=%0d exp=3", bus_a.stall_cnt_o); else passes++;
        apply(1'b1, 1'b0, 1'b0, 1'b1, 32'h200); tick();
        checks++; if (bus_a.pc_o !== 32'h200) $display("FAIL stall_br got=%h exp=%h", bus_a.pc_o, 32'h200); else passes++;
        checks++; if (bus_a.stall_timeout_o !== 1'b0) $display("FAIL stall_to got=%b exp=0", bus_a.stall_timeout_o); else passes++;
    endtask

    task automatic test_misaligned();
        restart();
        apply(1'b1, 1'b0, 1'b0, 1'b1, 32'h102);
        checks++; if (bus_a.flush_o !== 1'b1 || bus_a.pc_we_o !== 1'b0 || bus_a.ifid_we_o !== 1'b0) $display("FAIL mis_ctl got fl=%b we=%b ifid=%b exp 1 0 0", bus_a.flush_o, bus_a.pc_we_o, bus_a.ifid_we_o); else passes++;
        tick();
        checks++; if (bus_a.fault_o !== 1'b1 || bus_a.pc_o !== 32'h0) $display("FAIL mis_halt got fault=%b pc=%h exp 1 0", bus_a.fault_o, bus_a.pc_o); else passes++;
        apply(1'b1, 1'b1, 1'b0, 1'b1, 32'h100); tick(); tick();
        checks++; if (bus_a.pc_o !== 32'h0 || bus_a.pc_we_o !== 1'b0 || bus_a.flush_o !== 1'b0 || bus_a.sel_taken_o !== 1'b0) $display("FAIL mis_frozen got pc=%h we=%b fl=%b sel=%b exp 0 0 0 0", bus_a.pc_o, bus_a.pc_we_o, bus_a.flush_o, bus_a.sel_taken_o); else passes++;
        apply(1'b0, 1'b0, 1'b0, 1'b0, 32'h0); tick();
        apply(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (bus_a.fault_o !== 1'b0 || bus_a.pc_o !== 32'h0) $display("FAIL mis_reset got fault=%b pc=%h exp 0 0", bus_a.fault_o, bus_a.pc_o); else passes++;
    endtask

    task automatic test_watchdog();
        restart();
        apply(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        tick(); tick(); tick();
        checks++; if (bus_a.stall_timeout_o !== 1'b0) $display("FAIL wd_early got=%b exp=0", bus_a.stall_timeout_o); else passes++;
        tick();
        checks++; if (bus_a.stall_timeout_o !== 1'b1) $display("FAIL wd_fire got=%b exp=1", bus_a.stall_timeout_o); else passes++;
        apply(1'b1, 1'b0, 1'b0, 1'b0, 32'h0); tick();
        checks++; if (bus_a.stall_timeout_o !== 1'b1) $display("FAIL wd_sticky got=%b exp=1", bus_a.stall_timeout_o); else passes++;
        restart();
        apply(1'b1, 1'b0, 1'b1, 1'b0, 32'h0); tick(); tick(); tick();
        apply(1'b1, 1'b0, 1'b0, 1'b0, 32'h0); tick();
        apply(1'b1, 1'b0, 1'b1, 1'b0, 32'h0); tick(); tick(); tick();
        checks++; if (bus_a.stall_timeout_o !== 1'b0) $display("FAIL wd_split got=%b exp=0", bus_a.stall_timeout_o); else passes++;
        checks++; if (bus_a.stall_cnt_o !== 16'd6) $display("FAIL wd_scnt got=%0d exp=6", bus_a.stall_cnt_o); else passes++;
    endtask

    task automatic test_random();
        logic [101:0] exp_v, got_v;
        logic st, r, s, b;
        logic [31:0] t;
        restart();
        st = 1'b0;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 99) < 2 || (m_mode == M_HALT && $urandom_range(0, 9) == 0)) ? 1'b0 : 1'b1;
            s  = ($urandom_range(0, 1) == 1);
            st = st ? ($urandom_range(0, 99) < 80) : ($urandom_range(0, 99) < 25);
            b  = ($urandom_range(0, 99) < 30);
            t  = $urandom;
            if ($urandom_range(0, 9) != 0) t[1:0] = 2'b00;
            apply(r, s, st, b, t);
            exp_v = model_outs();
            got_v = dut_outs();
            checks++; if (got_v !== exp_v) $display("FAIL rand_cycle%0d got=%h exp=%h", i, got_v, exp_v); else passes++;
            tick();
        end
    endtask

    task automatic test_wrap_reset_pc();
        b_rst = 1'b0; @(posedge clk); #1;
        b_rst = 1'b1; b_start = 1'b1; #1;
        checks++; if (bus_b.pc_o !== 32'hFFFF_FFF8 || bus_b.pc_we_o !== 1'b0) $display("FAIL wrap_idle got pc=%h we=%b exp FFFFFFF8 0", bus_b.pc_o, bus_b.pc_we_o); else passes++;
        @(posedge clk); #1; b_start = 1'b0; #1;
        checks++; if (bus_b.pc_o !== 32'hFFFF_FFF8 || bus_b.pc_we_o !== 1'b1) $display("FAIL wrap_run got pc=%h we=%b exp FFFFFFF8 1", bus_b.pc_o, bus_b.pc_we_o); else passes++;
        @(posedge clk); #1;
        checks++; if (bus_b.pc_o !== 32'hFFFF_FFFC || bus_b.pc_plus4_o !== 32'h0) $display("FAIL wrap_top got pc=%h p4=%h exp FFFFFFFC 0", bus_b.pc_o, bus_b.pc_plus4_o); else passes++;
        @(posedge clk); #1;
        checks++; if (bus_b.pc_o !== 32'h0 || bus_b.fault_o !== 1'b0) $display("FAIL wrap_zero got pc=%h fault=%b exp 0 0", bus_b.pc_o, bus_b.fault_o); else passes++;
        @(posedge clk); #1;
        checks++; if (bus_b.pc_o !== 32'h4) $display("FAIL wrap_four got=%h exp=4", bus_b.pc_o); else passes++;
        b_stall = 1'b1; @(posedge clk); #1;
        checks++; if (bus_b.pc_o !== 32'h4 || bus_b.stall_cnt_o !== 16'd1) $display("FAIL wrap_stall got pc=%h scnt=%0d exp 4 1", bus_b.pc_o, bus_b.stall_cnt_o); else passes++;
        b_rst = 1'b0; @(posedge clk); #1;
        b_rst = 1'b1; b_stall = 1'b0; #1;
        checks++; if (bus_b.pc_o !== 32'hFFFF_FFF8 || bus_b.pc_we_o !== 1'b0 || bus_b.stall_cnt_o !== 16'd0) $display("FAIL wrap_rst got pc=%h we=%b scnt=%0d exp FFFFFFF8 0 0", bus_b.pc_o, bus_b.pc_we_o, bus_b.stall_cnt_o); else passes++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_stall_branch();
        test_misaligned();
        test_watchdog();
        test_random();
        test_wrap_reset_pc();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter of the pipelined CPU and sequences the next-PC selection mux.
- Drives the mux select (branch taken vs. PC+4), the PC write enable, the IF/ID write enable and the IF/ID flush.
- Resolves stall/branch priority, traps misaligned branch targets into a HALT state, and keeps stall/redirect performance counters with a stall watchdog.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- STALL_LIMIT, 16, consecutive stall cycles after which stall_timeout_o is set.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, synchronous, active-low.
- start_i  input  1  leaves IDLE; sampled only in IDLE.
- stall_i  input  1  load-use hazard from the hazard unit; freeze PC and IF/ID.
- branch_i  input  1  branch resolved taken in ID this cycle.
- branch_target_i  input  32  target address, valid when branch_i=1.
- pc_o  output  32  current PC register (fetch address).
- pc_plus4_o  output  32  pc_o + 4, mod 2^32 (not-taken mux input).
- sel_taken_o  output  1  mux select: 1 = target, 0 = PC+4.
- pc_we_o  output  1  PC register update this cycle.
- ifid_we_o  output  1  IF/ID write enable.
- flush_o  output  1  IF/ID flush (squash fetched instruction).
- fault_o  output  1  sticky: misaligned branch target taken.
- stall_timeout_o  output  1  sticky watchdog flag.
- stall_cnt_o  output  16  total stall cycles, saturating at 16'hFFFF.
- redirect_cnt_o  output  16  total taken redirects, saturating at 16'hFFFF.

Behaviour:
- Reset (rst_i=0 at a rising edge):
  - pc_o=RESET_PC, state=IDLE.
  - fault_o=0, stall_timeout_o=0, both counters=0, internal run-length counter=0.
  - Reset takes effect from any state, including mid-stall or HALT.
- States: IDLE, RUN, HALT. Outputs are combinational from state and inputs; registers update on the edge.
- IDLE:
  - pc_we_o=0, ifid_we_o=0, flush_o=0, sel_taken_o=0.
  - start_i=1 moves to RUN on the next edge; PC is unchanged, so the first fetch is RESET_PC.
- RUN, priority stall > branch > sequential:
  - stall_i=1: pc_we_o=0, ifid_we_o=0, flush_o=0, sel_taken_o=0. branch_i is ignored because the hazard unit re-presents it after the stall. stall_cnt_o increments and the run-length counter increments.
  - stall_i=0, branch_i=1, branch_target_i[1:0]==0: sel_taken_o=1, pc_we_o=1, ifid_we_o=1, flush_o=1. Next pc_o=branch_target_i. redirect_cnt_o increments.
  - stall_i=0, branch_i=1, branch_target_i[1:0]!=0: pc_we_o=0, flush_o=1, ifid_we_o=0. Next state=HALT, fault_o<=1. PC holds the address of the fetch following the branch.
  - stall_i=0, branch_i=0: sel_taken_o=0, pc_we_o=1, ifid_we_o=1. Next pc_o=pc_o+4; wraps 32'hFFFF_FFFC to 0 with no flag.
  - The run-length counter clears on any cycle with stall_i=0.
  - When the run-length counter reaches STALL_LIMIT, stall_timeout_o<=1 (sticky until reset). The run-length counter saturates; operation continues.
- HALT:
  - pc_we_o=0, ifid_we_o=0, flush_o=0, sel_taken_o=0. PC frozen.
  - All inputs are ignored; only reset exits.
- start_i is ignored outside IDLE.
- Counters saturate and never wrap.

Test Plan:
- Reset, then start_i pulse: pc_o=0 for 2 cycles (IDLE, then first RUN cycle), then 4, 8, 12. pc_we_o=0 in IDLE and 1 in RUN.
- In RUN at pc=0x10, branch_i=1 with target 0x100: in that cycle sel_taken_o=1 and flush_o=1; next cycle pc_o=0x100, then 0x104; redirect_cnt_o=1.
- At pc=0x20, stall_i=1 for 3 cycles together with branch_i=1 and target 0x200: pc_o holds 0x20, ifid_we_o=0, flush_o=0, stall_cnt_o=3. Then stall_i=0 and branch_i=1: pc_o becomes 0x200.
- Branch with target 0x102: flush_o=1 that cycle; then HALT, fault_o=1, pc_o frozen. Further branch_i and start_i have no effect. rst_i=0 returns pc_o=0 and fault_o=0.
- With STALL_LIMIT=4, stall_i=1 for 4 consecutive cycles: stall_timeout_o=1 after the 4th edge and stays 1 after the stall ends. A 3-cycle stall, 1 free cycle, then another 3-cycle stall leaves it 0.
- RESET_PC=32'hFFFF_FFF8, then run: pc_o sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004. rst_i=0 asserted during a stall: next cycle state=IDLE and pc_o=RESET_PC.
